// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared constants and the reset preload image for data_memory.
//   DATA_W_DEFAULT / ADDR_W_DEFAULT : default word and address-bus widths
//   PRELOAD_COUNT                   : number of low words given a non-zero reset value
//   preload_word(k)                 : reset value of word k (k for k < PRELOAD_COUNT, else 0)
package data_memory_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned ADDR_W_DEFAULT = 64;
    localparam int unsigned PRELOAD_COUNT  = 8;

    function automatic logic [31:0] preload_word(input int unsigned k);
        return (k < PRELOAD_COUNT) ? 32'(k) : 32'd0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with a synchronous write port and an asynchronous read port.
// A synchronous reset reloads the preload image and takes priority over a write.
//   clk    : clock, writes and reset on rising edge
//   reset  : synchronous active-high, restores preload image
//   we     : write enable (already qualified by the caller's range check)
//   addr   : word index for both read and write
//   wdata  : write data
//   rdata  : combinational read of mem[addr]
module dmem_array
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= DATA_W'(preload_word(k));
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// data_memory: word-addressed single-port data memory for the MEM stage.
// Combinational read, synchronous write, synchronous reset reloads a constant image.
// Out-of-range addresses (address >= DEPTH) never alias: writes are dropped, reads return 0.
//   clk        : clock
//   reset      : synchronous active-high, restores preload image (wins over mem_write)
//   address    : word index from the ALU
//   mem_write  : write enable, sampled on rising clk
//   mem_read   : read enable, combinational gating of read_data
//   write_data : store data
//   read_data  : mem[address] when mem_read and in range, else 0
// Optional build macro DATA_MEMORY_RANGE_ERR_EN adds:
//   range_err        : combinational, access (read or write) to an out-of-range address
//   range_err_sticky : registered, set by range_err, cleared only by reset
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
`ifdef DATA_MEMORY_RANGE_ERR_EN
    ,
    output logic              range_err,
    output logic              range_err_sticky
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] array_rdata;

    // In range only when every bit above the index field is zero, so no wrap-around.
    assign in_range = (address[ADDR_W-1:IDX_W] == '0);
    assign idx      = address[IDX_W-1:0];

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (mem_write & in_range),
        .addr   (idx),
        .wdata  (write_data),
        .rdata  (array_rdata)
    );

    assign read_data = (mem_read && in_range) ? array_rdata : '0;

`ifdef DATA_MEMORY_RANGE_ERR_EN
    assign range_err = (mem_read | mem_write) & ~in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            range_err_sticky <= 1'b0;
        end else if (range_err) begin
            range_err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 64;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
`ifdef DATA_MEMORY_RANGE_ERR_EN
    logic              range_err;
    logic              range_err_sticky;
`endif

    data_memory #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .address          (address),
        .mem_write        (mem_write),
        .mem_read         (mem_read),
        .write_data       (write_data),
        .read_data        (read_data)
`ifdef DATA_MEMORY_RANGE_ERR_EN
        ,
        .range_err        (range_err),
        .range_err_sticky (range_err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              rst;
        logic              we;
        logic              re;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic              chk_pre;
        logic [DATA_W-1:0] pre;
        logic [DATA_W-1:0] post;
        logic              err_pre;
        logic              sticky_post;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic we, input logic re,
                                input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                                input logic chk_pre, input logic [DATA_W-1:0] pre,
                                input logic [DATA_W-1:0] post, input logic err_pre,
                                input logic sticky_post);
        vec_t v;
        v.rst = rst; v.we = we; v.re = re; v.addr = addr; v.wd = wd;
        v.chk_pre = chk_pre; v.pre = pre; v.post = post;
        v.err_pre = err_pre; v.sticky_post = sticky_post;
        return v;
    endfunction

    // Reference model: plain array plus the preload rule.
    logic [DATA_W-1:0] model [DEPTH];
    logic              model_sticky;

    function automatic logic [DATA_W-1:0] preload(input int unsigned k);
        return (k < 8) ? DATA_W'(k) : '0;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic re, input logic [ADDR_W-1:0] a);
        if (re && a < 64'(DEPTH)) return model[a[7:0]];
        return '0;
    endfunction

    task automatic model_edge(input logic rst, input logic we, input logic re,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) model[k] = preload(k);
            model_sticky = 1'b0;
        end else begin
            if (we && a < 64'(DEPTH)) model[a[7:0]] = wd;
            if ((we || re) && a >= 64'(DEPTH)) model_sticky = 1'b1;
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic re,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        reset = rst; mem_write = we; mem_read = re; address = a; write_data = wd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        //           rst   we    re    addr                    wd            chk   pre           post          err   stk
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 64'd0,   32'd0,        1'b0, 32'd0,        32'd0,        1'b0, 1'b0));
        for (int k = 1; k < 8; k++)
            vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'(k), 32'd0,     1'b1, 32'(k),       32'(k),       1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd8,   32'd0,        1'b1, 32'd0,        32'd0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 64'd7,   32'd12345,    1'b1, 32'd0,        32'd0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd7,   32'd0,        1'b1, 32'd12345,    32'd12345,    1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd6,   32'd0,        1'b1, 32'd6,        32'd6,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 64'd7,   32'd0,        1'b1, 32'd0,        32'd0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 64'd300, 32'hDEADBEEF, 1'b1, 32'd0,        32'd0,        1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd44,  32'd0,        1'b1, 32'd0,        32'd0,        1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 64'd3,   32'hA5A5A5A5, 1'b1, 32'd3,        32'd3,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 64'd5,   32'd99,       1'b1, 32'd5,        32'd99,       1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd5,   32'd0,        1'b1, 32'd99,       32'd99,       1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'hFFFF_0000_0000_0005, 32'd0, 1'b1, 32'd0, 32'd0,    1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd256, 32'd0,        1'b1, 32'd0,        32'd0,        1'b1, 1'b1));

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd);
            #1;
            if (vecs[i].chk_pre) begin
                check($sformatf("vec%0d pre read_data", i), 64'(read_data), 64'(vecs[i].pre));
`ifdef DATA_MEMORY_RANGE_ERR_EN
                check($sformatf("vec%0d range_err", i), 64'(range_err), 64'(vecs[i].err_pre));
`endif
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d post read_data", i), 64'(read_data), 64'(vecs[i].post));
`ifdef DATA_MEMORY_RANGE_ERR_EN
            check($sformatf("vec%0d sticky", i), 64'(range_err_sticky), 64'(vecs[i].sticky_post));
`endif
        end

        // Hand sequence: mem_read rising on a held address updates with no clock edge.
        drive(1'b0, 1'b1, 1'b0, 64'd7, 32'd12345);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 64'd7, 32'd0);
        #1;
        check("read gated off", 64'(read_data), 64'd0);
        mem_read = 1'b1;
        #1;
        check("read raised no edge", 64'(read_data), 64'd12345);

        // Randomized phase against the model, starting from a clean reset.
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        model_edge(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 3000; n++) begin
            logic              r_rst, r_we, r_re;
            logic [ADDR_W-1:0] r_a;
            logic [DATA_W-1:0] r_wd;
            int unsigned       mode;
            r_rst = ($urandom_range(0, 59) == 0);
            r_we  = $urandom_range(0, 1) == 1;
            r_re  = $urandom_range(0, 3) != 0;
            r_wd  = $urandom;
            mode  = $urandom_range(0, 9);
            if (mode < 6)       r_a = 64'($urandom_range(0, DEPTH - 1));
            else if (mode == 6) r_a = 64'(DEPTH + $urandom_range(0, DEPTH - 1));
            else if (mode == 7) r_a = {32'($urandom), 32'($urandom)};
            else                r_a = 64'($urandom_range(0, 7));
            drive(r_rst, r_we, r_re, r_a, r_wd);
            #1;
            check("rand pre", 64'(read_data), 64'(model_read(r_re, r_a)));
`ifdef DATA_MEMORY_RANGE_ERR_EN
            check("rand range_err", 64'(range_err), 64'((r_we || r_re) && r_a >= 64'(DEPTH)));
`endif
            model_edge(r_rst, r_we, r_re, r_a, r_wd);
            @(posedge clk);
            #1;
            check("rand post", 64'(read_data), 64'(model_read(r_re, r_a)));
`ifdef DATA_MEMORY_RANGE_ERR_EN
            check("rand sticky", 64'(range_err_sticky), 64'(model_sticky));
`endif
        end

        // Final sweep of the whole array against the model.
        for (int k = 0; k < int'(DEPTH); k++) begin
            drive(1'b0, 1'b0, 1'b1, 64'(k), '0);
            #1;
            check($sformatf("sweep %0d", k), 64'(read_data), 64'(model[k]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
